// File: rtl/ad7606_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad7606_pkg
// Description : Shared types and sizes for the AD7606 acquisition controller.
//               Holds the controller state encoding and the frame geometry
//               (channels per frame, sample width, frame-tag width).
// Revision    : 1.0 - initial release
// ============================================================================
package ad7606_pkg;

    localparam int NUM_CH   = 8;
    localparam int CH_W     = 16;
    localparam int FRAME_W  = 16;
    localparam int CH_IDX_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_IDLE      = 3'd2,
        ST_RUN       = 3'd3,
        ST_STOP      = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ad7606_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : ad7606_frame_buf
// Description : Single-frame buffer and serialiser. Captures one 8-channel
//               frame on load_i and emits it ch1..ch8 as a valid/ready
//               word stream carrying channel index and frame tag.
// Ports       : sys_clk, rst      - clock, async active-high reset
//               load_i, data_i    - frame capture strobe and packed samples
//               tag_i             - frame tag stored with the frame
//               m_ready_i         - downstream ready
//               empty_o           - buffer can accept a frame this cycle
//               m_*_o             - stream word, channel, tag, last, valid
// Revision    : 1.0 - initial release
// ============================================================================
module ad7606_frame_buf
    import ad7606_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [NUM_CH*CH_W-1:0] data_i,
    input  logic [FRAME_W-1:0]     tag_i,
    input  logic                   m_ready_i,
    output logic                   empty_o,
    output logic [CH_W-1:0]        m_data_o,
    output logic [CH_IDX_W-1:0]    m_ch_o,
    output logic [FRAME_W-1:0]     m_frame_o,
    output logic                   m_last_o,
    output logic                   m_valid_o
);

    logic [NUM_CH-1:0][CH_W-1:0] buf_q;
    logic                        full_q;
    logic [CH_IDX_W-1:0]         ch_q;
    logic [FRAME_W-1:0]          tag_q;

    logic last_word;
    logic xfer;

    assign last_word = full_q && (ch_q == CH_IDX_W'(NUM_CH - 1));
    assign xfer      = full_q && m_ready_i;
    // The final handshake frees the buffer in the same cycle so a frame
    // arriving alongside it is not lost.
    assign empty_o   = !full_q || (xfer && last_word);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            full_q <= 1'b0;
            ch_q   <= '0;
            tag_q  <= '0;
        end else if (load_i) begin
            buf_q  <= data_i;
            tag_q  <= tag_i;
            ch_q   <= '0;
            full_q <= 1'b1;
        end else if (xfer) begin
            if (last_word) begin
                full_q <= 1'b0;
                ch_q   <= '0;
            end else begin
                ch_q   <= ch_q + CH_IDX_W'(1);
            end
        end
    end

    assign m_data_o  = buf_q[ch_q];
    assign m_ch_o    = ch_q;
    assign m_frame_o = tag_q;
    assign m_last_o  = last_word;
    assign m_valid_o = full_q;

endmodule
`default_nettype wire

// File: rtl/ad7606_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ad7606_acq_ctrl
// Description : AD7606 acquisition sequencer. Pulses the ADC reset, waits
//               for settling, gates conversions for continuous or fixed
//               bursts and streams each accepted frame word by word.
// Ports       : sys_clk, rst            - clock, async active-high reset
//               cmd_start, cmd_stop     - acquisition control pulses
//               cfg_os/range/burst_len  - settings latched on start
//               adc_reset/os/range/convst_en - capture block controls
//               adc_read_done, ch_data  - completed frame from capture block
//               m_data/ch/frame/last/valid, m_ready - output word stream
//               busy, overrun           - status
// Revision    : 1.0 - initial release
// ============================================================================
module ad7606_acq_ctrl
    import ad7606_pkg::*;
#(
    parameter int RESET_CYCLES  = 10,
    parameter int SETTLE_CYCLES = 100
)
(
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   cmd_start,
    input  logic                   cmd_stop,
    input  logic [2:0]             cfg_os,
    input  logic                   cfg_range,
    input  logic [15:0]            cfg_burst_len,
    output logic                   adc_reset,
    output logic [2:0]             adc_os,
    output logic                   adc_range,
    output logic                   adc_convst_en,
    input  logic                   adc_read_done,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    output logic [CH_W-1:0]        m_data,
    output logic [CH_IDX_W-1:0]    m_ch,
    output logic [FRAME_W-1:0]     m_frame,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   overrun
);

    localparam int MAX_CYC = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Set by the first accepted start; distinguishes the power-up settle
    // (ends in IDLE) from an acquisition settle (ends in RUN).
    logic                acq_q;
    logic [2:0]          os_q;
    logic                range_q;
    logic [15:0]         burst_q;
    logic [FRAME_W-1:0]  frame_q;
    logic                overrun_q;

    logic                buf_empty;
    logic                start_ok;
    logic                rd_accept;
    logic                rd_drop;
    logic                burst_done;
    logic [FRAME_W-1:0]  frame_nxt;

    // Stop has priority; a simultaneous start/stop in IDLE does nothing.
    assign start_ok   = (state_q == ST_IDLE) && cmd_start && !cmd_stop;
    assign rd_accept  = (state_q == ST_RUN) && adc_read_done && buf_empty;
    assign rd_drop    = (state_q == ST_RUN) && adc_read_done && !buf_empty;
    assign frame_nxt  = frame_q + FRAME_W'(1);
    assign burst_done = rd_accept && (burst_q != 16'd0) && (frame_nxt == burst_q);

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST_PULSE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST_PULSE: begin
                if (cmd_stop)
                    state_d = ST_STOP;
                else if (cnt_q == CNT_W'(RESET_CYCLES - 1))
                    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cmd_stop)
                    state_d = ST_STOP;
                else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1))
                    state_d = acq_q ? ST_RUN : ST_IDLE;
            end
            ST_IDLE: begin
                if (start_ok)
                    state_d = ST_RST_PULSE;
            end
            ST_RUN: begin
                if (cmd_stop || burst_done)
                    state_d = ST_STOP;
            end
            ST_STOP: begin
                if (buf_empty)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        adc_reset     = (state_q == ST_RST_PULSE);
        adc_convst_en = (state_q == ST_RUN);
        busy          = (state_q != ST_IDLE);
    end

    // Phase timer: restarts on every state change, only runs in the timed states.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_RST_PULSE || state_q == ST_SETTLE) && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Configuration, frame counter and overrun flag.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            acq_q     <= 1'b0;
            os_q      <= 3'd0;
            range_q   <= 1'b0;
            burst_q   <= 16'd0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
        end else if (start_ok) begin
            acq_q     <= 1'b1;
            os_q      <= cfg_os;
            range_q   <= cfg_range;
            burst_q   <= cfg_burst_len;
            frame_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (rd_accept)
                frame_q <= frame_nxt;
            if (rd_drop)
                overrun_q <= 1'b1;
        end
    end

    assign adc_os    = os_q;
    assign adc_range = range_q;
    assign overrun   = overrun_q;

    ad7606_frame_buf u_frame_buf (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .load_i    (rd_accept),
        .data_i    (ch_data),
        .tag_i     (frame_nxt),
        .m_ready_i (m_ready),
        .empty_o   (buf_empty),
        .m_data_o  (m_data),
        .m_ch_o    (m_ch),
        .m_frame_o (m_frame),
        .m_last_o  (m_last),
        .m_valid_o (m_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_ad7606_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad7606_acq_ctrl
// Description : Directed self-checking bench for ad7606_acq_ctrl: power-up
//               sequencing, bursts, backpressure/overrun, stop, refill on
//               the last handshake and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad7606_acq_ctrl;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         cmd_start;
    logic         cmd_stop;
    logic [2:0]   cfg_os;
    logic         cfg_range;
    logic [15:0]  cfg_burst_len;
    logic         adc_reset;
    logic [2:0]   adc_os;
    logic         adc_range;
    logic         adc_convst_en;
    logic         adc_read_done;
    logic [127:0] ch_data;
    logic [15:0]  m_data;
    logic [2:0]   m_ch;
    logic [15:0]  m_frame;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;
    logic         busy;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    ad7606_acq_ctrl #(
        .RESET_CYCLES  (10),
        .SETTLE_CYCLES (100)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_stop      (cmd_stop),
        .cfg_os        (cfg_os),
        .cfg_range     (cfg_range),
        .cfg_burst_len (cfg_burst_len),
        .adc_reset     (adc_reset),
        .adc_os        (adc_os),
        .adc_range     (adc_range),
        .adc_convst_en (adc_convst_en),
        .adc_read_done (adc_read_done),
        .ch_data       (ch_data),
        .m_data        (m_data),
        .m_ch          (m_ch),
        .m_frame       (m_frame),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [127:0] frame_data(input logic [15:0] base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = base + 16'(i);
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctrl"}, {adc_reset, adc_convst_en, adc_os, adc_range, busy, overrun},
              {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0});
        check({tag, " stream"}, {m_valid, m_last, m_ch, m_data, m_frame}, 37'd0);
    endtask

    task automatic pulse_start(input logic [2:0] os, input logic rng, input logic [15:0] len);
        cfg_os        = os;
        cfg_range     = rng;
        cfg_burst_len = len;
        cmd_start     = 1'b1;
        tick;
        cmd_start     = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!adc_convst_en && n < 1000) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick;
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic read_frame(input logic [15:0] base);
        ch_data       = frame_data(base);
        adc_read_done = 1'b1;
        tick;
        adc_read_done = 1'b0;
    endtask

    // Collect n words starting at channel 'first' of a frame built from 'base'.
    task automatic collect(input logic [15:0] base, input logic [15:0] tag, input int first, input int n);
        int          w;
        logic [15:0] d;
        logic [2:0]  c;
        logic        l;
        m_ready = 1'b1;
        for (int i = first; i < first + n; i++) begin
            w = 0;
            while (!m_valid && w < 50) begin
                tick;
                w++;
            end
            d = base + 16'(i);
            c = 3'(i);
            l = (i == 7);
            check($sformatf("word frame%0d ch%0d", tag, i),
                  {m_valid, m_data, m_ch, m_last, m_frame}, {1'b1, d, c, l, tag});
            tick;
        end
    endtask

    task automatic count_extra(input string tag);
        int extra;
        extra = 0;
        repeat (4) begin
            if (m_valid) extra++;
            tick;
        end
        check(tag, extra, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        rst           = 1'b1;
        cmd_start     = 1'b0;
        cmd_stop      = 1'b0;
        cfg_os        = 3'd0;
        cfg_range     = 1'b0;
        cfg_burst_len = 16'd0;
        adc_read_done = 1'b0;
        ch_data       = '0;
        m_ready       = 1'b0;

        // ---------------- power-up ----------------
        repeat (3) tick;
        check_reset_outputs("por");
        rst = 1'b0;
        n = 0;
        while (adc_reset && n < 1000) begin
            n++;
            tick;
        end
        check("por reset length", n, 10);
        n   = 0;
        bad = 0;
        while (busy && n < 1000) begin
            if (adc_convst_en || adc_reset) bad++;
            n++;
            tick;
        end
        check("por settle length", n, 100);
        check("por settle quiet", bad, 0);
        check("idle convst", adc_convst_en, 1'b0);

        // ---------------- start+stop together in IDLE ----------------
        cfg_os    = 3'b111;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        tick;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        tick;
        check("start+stop idle", {busy, adc_reset, adc_os}, {1'b0, 1'b0, 3'd0});

        // ---------------- burst of 3 ----------------
        pulse_start(3'b010, 1'b0, 16'd3);
        check("burst os/reset at t+1", {adc_os, adc_reset}, {3'b010, 1'b1});
        wait_run(n);
        check("burst start latency", n, 110);
        for (int f = 1; f <= 3; f++) begin
            read_frame(16'h1001);
            collect(16'h1001, 16'(f), 0, 8);
        end
        check("burst end state", {busy, adc_convst_en, adc_os, overrun}, {1'b0, 1'b0, 3'b010, 1'b0});

        // ---------------- backpressure and overrun ----------------
        pulse_start(3'b101, 1'b1, 16'd0);
        wait_run(n);
        check("bp run", adc_convst_en, 1'b1);
        m_ready = 1'b0;
        read_frame(16'h2001);
        tick;
        read_frame(16'h3001);
        check("bp overrun", overrun, 1'b1);
        check("bp hold", {m_valid, m_data, m_ch, m_frame}, {1'b1, 16'h2001, 3'd0, 16'd1});
        check("bp range", adc_range, 1'b1);
        collect(16'h2001, 16'd1, 0, 8);
        count_extra("bp extra words");
        cmd_stop = 1'b1;
        tick;
        cmd_stop = 1'b0;
        wait_idle("bp stop idle");

        // ---------------- stop in continuous mode ----------------
        pulse_start(3'b001, 1'b0, 16'd0);
        wait_run(n);
        check("stop run", {adc_convst_en, overrun}, {1'b1, 1'b0});
        read_frame(16'h4001);
        collect(16'h4001, 16'd1, 0, 3);
        m_ready  = 1'b0;
        cmd_stop = 1'b1;
        tick;
        cmd_stop = 1'b0;
        check("stop convst/busy", {adc_convst_en, busy}, {1'b0, 1'b1});
        read_frame(16'h5001);
        check("stop read ignored", {overrun, m_valid, m_data, m_ch, m_frame},
              {1'b0, 1'b1, 16'h4004, 3'd3, 16'd1});
        collect(16'h4001, 16'd1, 3, 5);
        count_extra("stop extra words");
        check("stop idle", busy, 1'b0);

        // ---------------- refill on final handshake ----------------
        pulse_start(3'b011, 1'b1, 16'd0);
        wait_run(n);
        check("refill run", adc_convst_en, 1'b1);
        read_frame(16'h6001);
        collect(16'h6001, 16'd1, 0, 7);
        check("pre-refill last word", {m_valid, m_ch, m_last, m_data}, {1'b1, 3'd7, 1'b1, 16'h6008});
        ch_data       = frame_data(16'h7001);
        adc_read_done = 1'b1;
        tick;
        adc_read_done = 1'b0;
        check("refill next ch1", {m_valid, m_data, m_ch, m_last, m_frame},
              {1'b1, 16'h7001, 3'd0, 1'b0, 16'd2});
        check("refill overrun", overrun, 1'b0);
        collect(16'h7001, 16'd2, 0, 2);

        // ---------------- async reset during RUN ----------------
        check("pre-reset state", {busy, adc_convst_en, adc_os, m_ch}, {1'b1, 1'b1, 3'b011, 3'd2});
        rst = 1'b1;
        #1;
        check_reset_outputs("rst in run");
        tick;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad7606_acq_ctrl.md
# ad7606_acq_ctrl

Acquisition controller that sequences the AD7606 capture path. It holds the ADC in reset at power-up, applies oversampling and range configuration, and gates conversions for continuous or fixed-length bursts. It buffers each completed 8-channel frame and serialises it as a valid/ready word stream with channel index and frame tag. It sits between the software/register layer and the parallel capture block, driving that block's reset, OS, range and conversion-enable inputs.

## Interface
- RESET_CYCLES, 10: ADC reset pulse length in sys_clk cycles, minimum 1.
- SETTLE_CYCLES, 100: wait after the reset pulse ends and before conversions are enabled, minimum 1.
- sys_clk  in  1  clock, sole clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  single-cycle pulse that starts an acquisition.
- cmd_stop  in  1  single-cycle pulse that aborts an acquisition.
- cfg_os  in  3  oversampling code, latched on an accepted cmd_start.
- cfg_range  in  1  input range select (0 = ±5 V, 1 = ±10 V), latched on an accepted cmd_start.
- cfg_burst_len  in  16  number of frames per acquisition; 0 means continuous. Latched on an accepted cmd_start.
- adc_reset  out  1  ADC reset, active-high.
- adc_os  out  3  latched oversampling code.
- adc_range  out  1  latched range select.
- adc_convst_en  out  1  conversion enable to the capture block.
- adc_read_done  in  1  single-cycle pulse; ch_data is valid in the same cycle.
- ch_data  in  128  channel data packed {ch8,…,ch1}, with ch1 in [15:0].
- m_data  out  16  output sample word.
- m_ch  out  3  channel index of m_data (0 = ch1).
- m_frame  out  16  frame tag of m_data.
- m_last  out  1  high on the ch8 word.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky flag: a frame was dropped because the buffer was full.

## Operation
- **States:** RST_PULSE, SETTLE, IDLE, RUN, STOP.
- **After reset:**
  - The block enters RST_PULSE with adc_reset = 1 for RESET_CYCLES cycles.
  - It then moves to SETTLE for SETTLE_CYCLES cycles.
  - The first pass through SETTLE goes to IDLE.
  - Any later pass (one started by cmd_start) goes to RUN.
- **IDLE:**
  - An accepted cmd_start latches cfg_os, cfg_range and cfg_burst_len.
  - It clears overrun and the frame counter.
  - It then enters RST_PULSE, so every acquisition begins with a fresh ADC reset carrying the new OS and range settings.
- **RUN:**
  - adc_convst_en = 1.
  - On adc_read_done with the buffer empty, all 8 words are latched, the buffer is marked full, and the frame counter increments (it wraps at 16 bits).
  - On adc_read_done with the buffer full, the frame is dropped, overrun is set, and the frame is not counted.
- **Burst completion:** when cfg_burst_len ≠ 0 and the accepted-frame count reaches cfg_burst_len, the block enters STOP.
- **cmd_stop:**
  - In RUN, RST_PULSE or SETTLE it forces STOP.
  - In IDLE it is ignored.
  - A cmd_start in any state other than IDLE is ignored.
  - If cmd_start and cmd_stop arrive in the same cycle, stop wins; in IDLE, both are ignored.
- **STOP:**
  - adc_convst_en = 0.
  - An adc_read_done arriving in STOP is dropped silently: no count, no overrun.
  - The block goes to IDLE once the buffer has drained.
- **Serialiser:**
  - Emits ch1..ch8 in order.
  - m_frame carries the tag of the frame being emitted (the count value assigned when that frame was accepted; 1 for the first frame).
  - A word advances only when m_valid and m_ready are both high.
  - m_last is high on the ch8 word; the buffer is empty after that word's handshake.
  - m_data, m_ch, m_frame and m_last hold stable while m_valid is high and m_ready is low.
- **Buffer refill:** an adc_read_done in the same cycle as the final ch8 handshake is accepted, because the buffer counts as empty in that cycle.

## Timing
- **Reset values:**
  - adc_reset = 1, adc_convst_en = 0, adc_os = 0, adc_range = 0.
  - m_valid = 0, m_data = 0, m_ch = 0, m_frame = 0, m_last = 0.
  - busy = 1, overrun = 0.
- rst asserted mid-operation returns every output to its reset value asynchronously and discards the buffer.
- adc_read_done at cycle t produces m_valid = 1 with ch1 at t+1.
- With m_ready held high, one word transfers per cycle, so the full frame completes at t+8.
- cmd_start accepted at cycle t gives adc_reset = 1 from t+1 through t+RESET_CYCLES, then SETTLE_CYCLES cycles with adc_reset = 0, then adc_convst_en = 1 on the next cycle.
- adc_os and adc_range update at t+1 and stay stable until the next accepted start.
- cmd_stop at cycle t gives adc_convst_en = 0 at t+1.

## Structure
- **Package ad7606_pkg:**
  - State enum.
  - NUM_CH = 8.
  - CH_W = 16.
  - FRAME_W = 16.
- **Sub-module ad7606_frame_buf:** 8×16 frame register, full flag, channel counter and valid/ready serialiser. It has a load input and an empty output.
- The top level holds the FSM, the cycle counter (sized to the larger of RESET_CYCLES and SETTLE_CYCLES) and the frame counter.

## Test plan
- **Power-up:** deassert rst, wait for IDLE → adc_reset = 1 for exactly 10 cycles, busy falls after 100 further cycles, adc_convst_en = 0.
- **Burst:** cfg_burst_len = 3, cfg_os = 3'b010, cmd_start, then 3 read_done pulses with ch_data words 16'h1001..16'h1008, m_ready = 1:
  - 24 words appear with m_ch 0..7 and m_last on every 8th word.
  - m_frame = 1, 2, 3.
  - The block returns to IDLE and adc_os = 3'b010.
- **Backpressure and overrun:** m_ready = 0, two read_done pulses → overrun = 1, outputs held at the first frame's ch1, and that frame's tag is 1. Release m_ready → only 8 words are delivered.
- **Stop in continuous mode:** cfg_burst_len = 0, cmd_stop mid-frame → adc_convst_en = 0 next cycle, the remaining words drain, a read_done in STOP produces no output, then IDLE.
- **Corner cases:**
  - cmd_start and cmd_stop together in IDLE → no state change.
  - read_done coincident with the ch8 handshake → next ch1 appears the following cycle.
  - rst asserted in RUN → all outputs at their reset values immediately.
